seq_ctrl: RTL and testbench
===========================

# seq_ctrl

Multi-cycle stage sequencer for the sequential Y86-64 core. It drives one stage enable at a time through fetch, decode, execute, memory, writeback and PC update, in that order. It waits on a data-memory handshake for memory-class instructions and tracks the Y86 status code. It counts retired instructions and active cycles, and supports free-run and single-step operation.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles `mem_req` stays high without `mem_ack` before an ADR fault.
- `COUNT_W`, default 32: width of `instr_count` and `cycle_count`.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: level; while high, instructions execute back-to-back.
- `step` in 1: one-cycle pulse; executes exactly one instruction.
- `icode` in 4: from fetch, valid in FETCH.
- `instr_valid` in 1: from fetch, valid in FETCH.
- `imem_error` in 1: instruction address fault, valid in FETCH.
- `mem_ack` in 1: data memory completed the access.
- `dmem_error` in 1: data address fault, valid in MEMORY.
- `fetch_en`, `decode_en`, `exec_en`, `wb_en`, `pc_en` out 1 each: one-cycle stage strobes.
- `mem_en` out 1: high for every cycle spent in MEMORY.
- `mem_req` out 1: data access request.
- `stat` out 3: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- `busy` out 1: state is neither IDLE nor HALT.
- `halted` out 1: state is HALT.
- `instr_count` out COUNT_W: retired instructions.
- `cycle_count` out COUNT_W: active cycles.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT. The current state is encoded directly onto the strobes, so exactly one strobe is high in each non-IDLE, non-HALT state.
- IDLE → FETCH when `run` or `step` is high. `run` takes priority; a `step` arriving in any other state is ignored.
- FETCH: `fetch_en`=1. Faults are checked in this order:
  - `imem_error` → `stat`=ADR, go to HALT.
  - `!instr_valid` → `stat`=INS, go to HALT.
  - `icode`=0 (halt) → `stat`=HLT, `instr_count`+1, go to HALT.
  - Otherwise latch `icode` and go to DECODE.
- DECODE → EXECUTE → MEMORY, one cycle each.
- MEMORY, `mem_en`=1:
  - If the latched icode is in {4 rmmovq, 5 mrmovq, 8 call, 9 ret, A pushq, B popq}, `mem_req`=1 until exit. Otherwise `mem_req`=0 and the state exits after one cycle.
  - `dmem_error` → `stat`=ADR, go to HALT. This takes priority over `mem_ack` in the same cycle.
  - `mem_ack` → WRITEBACK.
  - After MEM_TIMEOUT consecutive request cycles with no ack → `stat`=ADR, go to HALT.
  - `mem_ack` arriving while `mem_req`=0 is ignored.
- WRITEBACK → PCUPD.
- PCUPD: `pc_en`=1 and `instr_count`+1. Next state:
  - `run` high → FETCH.
  - Otherwise → IDLE. This covers step mode, and a `run` that dropped mid-instruction (the instruction always completes).
- HALT is absorbing; only `rst` leaves it. No strobe, `mem_req` or count changes while halted.
- On any fault, `wb_en` and `pc_en` are never asserted for the faulting instruction, so architectural state is not committed.
- Counters:
  - `cycle_count` increments on every cycle where `busy`=1 (the halting FETCH cycle included).
  - Both counters saturate at all-ones and never wrap.
- Unlisted icodes that `instr_valid` accepts run the full sequence with no memory request.

## Timing
- Reset values: state IDLE; all strobes, `mem_req`, `busy`, `halted` = 0; `stat`=1 (AOK); both counters = 0.
- `rst` high in any state, including mid-MEMORY with `mem_req` high, overrides everything: the same edge returns to the reset values, and `mem_req` drops immediately.
- All outputs are registered or are pure decodes of registered state; no input combinationally reaches an output.
- Non-memory instruction: 6 cycles from FETCH to PCUPD.
- Memory instruction: 6 + w cycles, where w is the number of request cycles before the ack cycle. An ack on the first MEMORY cycle gives w=0.
- Back-to-back under `run`: FETCH follows PCUPD on the next cycle, so sustained throughput is 1 instruction per 6 cycles.
- `run`/`step` sampled in IDLE: FETCH begins on the next cycle, 1 cycle after the request.
- Timeout: with the ack never arriving, HALT is entered on cycle MEMORY+MEM_TIMEOUT. An ack on exactly the MEM_TIMEOUT-th request cycle is accepted.

## Structure
- Package `y86_pkg` holds:
  - icode constants: HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B.
  - stat constants: AOK, HLT, ADR, INS.
  - the state enum.
  - the `is_mem_icode` function.
- One sub-module, `sat_counter` (parameter W; inputs `inc`, `clr`), instantiated twice for the two counters.
- The timeout counter is local to `seq_ctrl`, width $clog2(MEM_TIMEOUT+1).

## Test plan
- Step a nop: `step` pulse with icode=1 → six strobes in order F, D, E, M, W, P; `mem_req` never high; `instr_count`=1, `cycle_count`=6; back in IDLE.
- Run three OPq instructions with `run` held → `pc_en` pulses at cycles 6, 12 and 18; `instr_count`=3; drop `run` during the third instruction → it completes and the block returns to IDLE.
- mrmovq with `mem_ack` after 3 wait cycles → `mem_en` high for 4 cycles, `mem_req` high for 4 cycles; instruction takes 9 cycles; `stat`=AOK.
- pushq with no ack, MEM_TIMEOUT=4 → HALT after 4 request cycles; `stat`=3; `wb_en` and `pc_en` never assert; `instr_count` unchanged.
- Faults in FETCH:
  - icode=0 → `stat`=2, `halted`=1, `instr_count` +1.
  - `instr_valid`=0 → `stat`=4.
  - `imem_error` with `instr_valid`=0 → `stat`=3 (ADR wins).
  - A later `run` or `step` does nothing in HALT.
- `rst` asserted mid-MEMORY with `mem_req` high → next cycle IDLE, `mem_req`=0, `stat`=1, counters 0; the same edge with `dmem_error` also high still yields reset values.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the sequential core: icodes, status codes, sequencer states.
// Latency: n/a (constants, types and a pure decode function only).
// Backpressure: n/a.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    // Instructions that touch data memory and therefore wait for mem_ack.
    function automatic logic is_mem_icode(input logic [3:0] ic);
        case (ic)
            ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL,
            ICODE_RET, ICODE_PUSHQ, ICODE_POPQ: is_mem_icode = 1'b1;
            default:                            is_mem_icode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Latency: count reflects inc/clr one cycle after they are sampled.
// Backpressure: none; inc is accepted every cycle, clr wins over inc.
// Ports: clk, clr (sync clear), inc (increment enable), count (W-bit value).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle stage sequencer: one stage strobe per cycle F,D,E,M,W,P with Y86 status tracking.
// Latency: 6 cycles per instruction, plus one per data-memory wait cycle before mem_ack.
// Backpressure: MEMORY holds mem_req until mem_ack, dmem_error or MEM_TIMEOUT request cycles.
// Ports: clk/rst, run/step control, fetch results (icode, instr_valid, imem_error),
//        data handshake (mem_ack, dmem_error), stage strobes, mem_req, stat, busy, halted, counters.
module seq_ctrl
    import y86_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    input  logic [3:0]         icode,
    input  logic               instr_valid,
    input  logic               imem_error,
    input  logic               mem_ack,
    input  logic               dmem_error,
    output logic               fetch_en,
    output logic               decode_en,
    output logic               exec_en,
    output logic               mem_en,
    output logic               wb_en,
    output logic               pc_en,
    output logic               mem_req,
    output logic [2:0]         stat,
    output logic               busy,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count,
    output logic [COUNT_W-1:0] cycle_count
);

    localparam int               TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state;
    logic [3:0]       icode_q;
    logic [2:0]       stat_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             instr_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            icode_q <= ICODE_NOP;
            stat_q  <= STAT_AOK;
            tmo_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run || step) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_error) begin
                        stat_q <= STAT_ADR;
                        state  <= S_HALT;
                    end else if (!instr_valid) begin
                        stat_q <= STAT_INS;
                        state  <= S_HALT;
                    end else if (icode == ICODE_HALT) begin
                        stat_q <= STAT_HLT;
                        state  <= S_HALT;
                    end else begin
                        icode_q <= icode;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXECUTE;
                S_EXECUTE: begin
                    tmo_cnt <= '0;
                    state   <= S_MEMORY;
                end
                S_MEMORY: begin
                    if (!is_mem_icode(icode_q)) begin
                        state <= S_WRITEBACK;
                    end else if (dmem_error) begin
                        stat_q <= STAT_ADR;
                        state  <= S_HALT;
                    end else if (mem_ack) begin
                        state <= S_WRITEBACK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Last allowed request cycle passed without ack.
                        stat_q <= STAT_ADR;
                        state  <= S_HALT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_WRITEBACK: state <= S_PCUPD;
                S_PCUPD: state <= run ? S_FETCH : S_IDLE;
                default: state <= S_HALT;
            endcase
        end
    end

    // Outputs are pure decodes of registered state.
    assign fetch_en  = (state == S_FETCH);
    assign decode_en = (state == S_DECODE);
    assign exec_en   = (state == S_EXECUTE);
    assign mem_en    = (state == S_MEMORY);
    assign wb_en     = (state == S_WRITEBACK);
    assign pc_en     = (state == S_PCUPD);
    assign mem_req   = mem_en && is_mem_icode(icode_q);
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);
    assign stat      = stat_q;

    // A fetched halt retires in FETCH; everything else retires in PCUPD.
    assign instr_inc = pc_en ||
                       (fetch_en && !imem_error && instr_valid && (icode == ICODE_HALT));

    sat_counter #(.W(COUNT_W)) u_instr_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (instr_inc),
        .count (instr_count)
    );

    sat_counter #(.W(COUNT_W)) u_cycle_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (busy),
        .count (cycle_count)
    );

endmodule

// File: tb/tb_seq_ctrl.sv
module tb_seq_ctrl;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, run, step, instr_valid, imem_error, mem_ack, dmem_error;
    logic [3:0]    icode;
    logic          fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, mem_req, busy, halted;
    logic [2:0]    stat;
    logic [CW-1:0] instr_count, cycle_count;

    int vectors    = 0;
    int miscompares = 0;

    seq_ctrl #(.MEM_TIMEOUT(4), .COUNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .mem_ack     (mem_ack),
        .dmem_error  (dmem_error),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .exec_en     (exec_en),
        .mem_en      (mem_en),
        .wb_en       (wb_en),
        .pc_en       (pc_en),
        .mem_req     (mem_req),
        .stat        (stat),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Strobe vector {F,D,E,M,W,P,mem_req}
    localparam logic [6:0] V_NONE = 7'b0000000;
    localparam logic [6:0] V_F    = 7'b1000000;
    localparam logic [6:0] V_D    = 7'b0100000;
    localparam logic [6:0] V_E    = 7'b0010000;
    localparam logic [6:0] V_M    = 7'b0001000;
    localparam logic [6:0] V_MR   = 7'b0001001;
    localparam logic [6:0] V_W    = 7'b0000100;
    localparam logic [6:0] V_P    = 7'b0000010;

    function automatic logic [6:0] strobes();
        return {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, mem_req};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; icode = 4'h1; instr_valid = 1'b1;
        imem_error = 1'b0; mem_ack = 1'b0; dmem_error = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_strobes", 32'(strobes()), 32'(V_NONE));
        check("rst_stat", 32'(stat), 32'd1);
        check("rst_busy_halted", 32'({busy, halted}), 32'd0);
        check("rst_instr_cnt", 32'(instr_count), 32'd0);
        check("rst_cycle_cnt", 32'(cycle_count), 32'd0);

        // Step a nop: F D E M W P, no mem_req; a stray ack in MEMORY is ignored
        icode = 4'h1; step = 1'b1;
        tick(); step = 1'b0; check("nop_F", 32'(strobes()), 32'(V_F));
        tick(); check("nop_D", 32'(strobes()), 32'(V_D));
        tick(); check("nop_E", 32'(strobes()), 32'(V_E));
        tick(); check("nop_M", 32'(strobes()), 32'(V_M));
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0; check("nop_W", 32'(strobes()), 32'(V_W));
        tick(); check("nop_P", 32'(strobes()), 32'(V_P));
        tick();
        check("nop_idle", 32'({busy, strobes()}), 32'd0);
        check("nop_instr_cnt", 32'(instr_count), 32'd1);
        check("nop_cycle_cnt", 32'(cycle_count), 32'd6);
        check("nop_stat", 32'(stat), 32'd1);

        // Three OPq under run; run drops during the third
        icode = 4'h6; run = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            check($sformatf("opq_pc_c%0d", c), 32'(pc_en), 32'((c % 6) == 0));
            check($sformatf("opq_f_c%0d", c), 32'(fetch_en), 32'((c % 6) == 1));
            if (c == 14) run = 1'b0;
        end
        tick();
        check("opq_idle", 32'(busy), 32'd0);
        check("opq_instr_cnt", 32'(instr_count), 32'd4);
        check("opq_cycle_cnt", 32'(cycle_count), 32'd24);

        // mrmovq, ack on 4th MEMORY cycle (= MEM_TIMEOUT-th request, accepted)
        icode = 4'h5; step = 1'b1;
        tick(); step = 1'b0; check("mr_F", 32'(strobes()), 32'(V_F));
        tick(); check("mr_D", 32'(strobes()), 32'(V_D));
        tick(); check("mr_E", 32'(strobes()), 32'(V_E));
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("mr_M%0d", k), 32'(strobes()), 32'(V_MR));
            if (k == 4) mem_ack = 1'b1;
        end
        tick(); mem_ack = 1'b0; check("mr_W", 32'(strobes()), 32'(V_W));
        tick(); check("mr_P", 32'(strobes()), 32'(V_P));
        tick();
        check("mr_stat", 32'(stat), 32'd1);
        check("mr_instr_cnt", 32'(instr_count), 32'd5);
        check("mr_cycle_cnt", 32'(cycle_count), 32'd33);

        // 40 nops under run: cycle_count 33+240 saturates at 255
        icode = 4'h1; run = 1'b1;
        for (int c = 1; c <= 240; c++) begin
            tick();
            if (c == 235) run = 1'b0;
        end
        tick();
        check("sat_idle", 32'(busy), 32'd0);
        check("sat_cycle_cnt", 32'(cycle_count), 32'd255);
        check("sat_instr_cnt", 32'(instr_count), 32'd45);

        // pushq with no ack: HALT after 4 request cycles
        do_reset();
        check("post_sat_rst_cnt", 32'(cycle_count), 32'd0);
        icode = 4'hA; step = 1'b1;
        tick(); step = 1'b0; check("push_F", 32'(strobes()), 32'(V_F));
        tick(); check("push_D", 32'(strobes()), 32'(V_D));
        tick(); check("push_E", 32'(strobes()), 32'(V_E));
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("push_M%0d", k), 32'(strobes()), 32'(V_MR));
        end
        tick();
        check("push_halt", 32'({halted, busy}), 32'b10);
        check("push_strobes", 32'(strobes()), 32'(V_NONE));
        check("push_stat", 32'(stat), 32'd3);
        check("push_instr_cnt", 32'(instr_count), 32'd0);
        check("push_cycle_cnt", 32'(cycle_count), 32'd7);
        run = 1'b1; step = 1'b1;
        tick(); tick();
        run = 1'b0; step = 1'b0;
        check("push_absorb", 32'({halted, strobes()}), 32'h80);
        check("push_absorb_cnt", 32'(cycle_count), 32'd7);

        // Fetched halt
        do_reset();
        icode = 4'h0; step = 1'b1;
        tick(); step = 1'b0; check("hlt_F", 32'(strobes()), 32'(V_F));
        tick();
        check("hlt_stat", 32'(stat), 32'd2);
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_instr_cnt", 32'(instr_count), 32'd1);
        check("hlt_cycle_cnt", 32'(cycle_count), 32'd1);
        run = 1'b1;
        tick(); tick();
        run = 1'b0;
        check("hlt_absorb", 32'({halted, strobes()}), 32'h80);
        check("hlt_absorb_cnt", 32'({instr_count, cycle_count}), 32'h0101);

        // Invalid instruction
        do_reset();
        icode = 4'h1; instr_valid = 1'b0; step = 1'b1;
        tick(); step = 1'b0;
        tick();
        check("ins_stat", 32'(stat), 32'd4);
        check("ins_instr_cnt", 32'(instr_count), 32'd0);

        // imem_error beats invalid
        do_reset();
        imem_error = 1'b1; step = 1'b1;
        tick(); step = 1'b0;
        tick();
        check("adr_f_stat", 32'(stat), 32'd3);
        check("adr_f_halted", 32'(halted), 32'd1);
        imem_error = 1'b0; instr_valid = 1'b1;

        // dmem_error beats mem_ack; no W/P for the faulting ret
        do_reset();
        icode = 4'h9; step = 1'b1;
        tick(); step = 1'b0;
        tick(); tick(); tick();
        check("ret_M", 32'(strobes()), 32'(V_MR));
        dmem_error = 1'b1; mem_ack = 1'b1;
        tick(); dmem_error = 1'b0; mem_ack = 1'b0;
        check("ret_halt", 32'({halted, strobes()}), 32'h80);
        check("ret_stat", 32'(stat), 32'd3);
        check("ret_instr_cnt", 32'(instr_count), 32'd0);

        // rst mid-MEMORY with dmem_error in the same cycle
        do_reset();
        icode = 4'h4; step = 1'b1;
        tick(); step = 1'b0;
        tick(); tick(); tick();
        check("rmm_M", 32'(strobes()), 32'(V_MR));
        rst = 1'b1; dmem_error = 1'b1;
        tick(); rst = 1'b0; dmem_error = 1'b0;
        check("midrst_strobes", 32'(strobes()), 32'(V_NONE));
        check("midrst_state", 32'({busy, halted}), 32'd0);
        check("midrst_stat", 32'(stat), 32'd1);
        check("midrst_cnts", 32'({instr_count, cycle_count}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
